// File: rtl/mac_rx_pkg.sv
// Shared encodings and constants for the MAC receive-buffer controller.
package mac_rx_pkg;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_HDR  = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_DROP = 2'd3;

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_FILL = 2'd1,
        SLOT_FULL = 2'd2,
        SLOT_READ = 2'd3
    } slot_state_t;

    localparam logic [47:0] BCAST_MAC       = 48'hFFFF_FFFF_FFFF;
    localparam int          MIN_LEN         = 14;
    localparam int          DEFAULT_MAX_LEN = 1518;

    // Unicast to us, broadcast, or group-addressed when multicast reception is on.
    function automatic logic dest_accepted(input logic [47:0] dest,
                                           input logic [47:0] local_addr,
                                           input logic        accept_mcast);
        return (dest == local_addr) || (dest == BCAST_MAC) || (dest[40] && accept_mcast);
    endfunction

endpackage

// File: rtl/mac_rx_buf_ctrl_if.sv
// Write side (MAC receive datapath) and read side (host reader) of the receive-buffer controller.
interface mac_rx_buf_ctrl_if #(
    parameter int SLOT_W = 1,
    parameter int LEN_W  = 11
);
    logic              wr_sof;
    logic              wr_hdr_valid;
    logic [47:0]       wr_dest_mac;
    logic              wr_eof;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_fcs_ok;
    logic              wr_slot_en;
    logic [SLOT_W-1:0] wr_slot;

    logic              rd_valid;
    logic [SLOT_W-1:0] rd_slot;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_ready;
    logic              rd_done;
    logic [SLOT_W-1:0] rd_done_slot;

    modport master (
        output wr_sof, wr_hdr_valid, wr_dest_mac, wr_eof, wr_len, wr_fcs_ok,
               rd_ready, rd_done, rd_done_slot,
        input  wr_slot_en, wr_slot, rd_valid, rd_slot, rd_len
    );

    modport slave (
        input  wr_sof, wr_hdr_valid, wr_dest_mac, wr_eof, wr_len, wr_fcs_ok,
               rd_ready, rd_done, rd_done_slot,
        output wr_slot_en, wr_slot, rd_valid, rd_slot, rd_len
    );
endinterface

// File: rtl/mac_rx_slot_fifo.sv
// In-order queue of committed {slot, len} entries; DEPTH must be a power of two.
module mac_rx_slot_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mac_rx_buf_ctrl.sv
// Receive-buffer controller: slot allocation, destination filtering, in-order ready queue.
// Statistics counters are built only when RX_STATS_EN is defined; otherwise cnt_* read 0.
module mac_rx_buf_ctrl
    import mac_rx_pkg::*;
#(
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = 1,
    parameter int LEN_W     = 11,
    parameter int MAX_LEN   = DEFAULT_MAX_LEN,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             config_ready,
    input  logic [47:0]      local_mac,
    input  logic             accept_mcast,
    input  logic             stats_clr,
    mac_rx_buf_ctrl_if.slave bus,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_nobuf,
    output logic [CNT_W-1:0] cnt_filt,
    output logic [CNT_W-1:0] cnt_err
);
    logic [1:0]        wstate_q;
    logic [1:0]        wstate_d;
    logic [SLOT_W-1:0] cur_slot_q;
    logic [SLOT_W-1:0] cur_slot_d;
    slot_state_t       slot_q [NUM_SLOTS];
    slot_state_t       slot_d [NUM_SLOTS];

    logic              free_found;
    logic [SLOT_W-1:0] free_idx;
    logic              in_frame;
    logic              len_ok;
    logic              free_cur;
    logic              commit_cur;
    logic              alloc;
    logic              inc_ok;
    logic              inc_nobuf;
    logic              inc_filt;
    logic              inc_err;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [SLOT_W+LEN_W-1:0] fifo_head;
    logic [SLOT_W-1:0]       head_slot;
    logic [LEN_W-1:0]        head_len;

    assign in_frame = (wstate_q == W_HDR) || (wstate_q == W_DATA);
    assign len_ok   = (bus.wr_len >= LEN_W'(MIN_LEN)) && (bus.wr_len <= LEN_W'(MAX_LEN));

    // Descending scan so the lowest-index FREE slot wins; registered state only.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_q[i] == SLOT_FREE) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        wstate_d   = wstate_q;
        cur_slot_d = cur_slot_q;
        free_cur   = 1'b0;
        commit_cur = 1'b0;
        alloc      = 1'b0;
        inc_ok     = 1'b0;
        inc_nobuf  = 1'b0;
        inc_filt   = 1'b0;
        inc_err    = 1'b0;
        if (!config_ready) begin
            free_cur = in_frame;
            wstate_d = W_IDLE;
        end else if (bus.wr_sof) begin
            // A new sof outside W_IDLE means the previous eof was lost.
            inc_err  = (wstate_q != W_IDLE);
            free_cur = in_frame;
            if (free_found) begin
                alloc      = 1'b1;
                cur_slot_d = free_idx;
                wstate_d   = W_HDR;
            end else begin
                inc_nobuf = 1'b1;
                wstate_d  = W_DROP;
            end
        end else begin
            case (wstate_q)
                W_HDR: begin
                    if (bus.wr_eof) begin
                        free_cur = 1'b1;
                        inc_err  = 1'b1;
                        wstate_d = W_IDLE;
                    end else if (bus.wr_hdr_valid) begin
                        if (dest_accepted(bus.wr_dest_mac, local_mac, accept_mcast)) begin
                            wstate_d = W_DATA;
                        end else begin
                            free_cur = 1'b1;
                            inc_filt = 1'b1;
                            wstate_d = W_DROP;
                        end
                    end
                end
                W_DATA: begin
                    if (bus.wr_eof) begin
                        if (bus.wr_fcs_ok && len_ok) begin
                            commit_cur = 1'b1;
                            inc_ok     = 1'b1;
                        end else begin
                            free_cur = 1'b1;
                            inc_err  = 1'b1;
                        end
                        wstate_d = W_IDLE;
                    end
                end
                W_DROP: begin
                    if (bus.wr_eof) begin
                        wstate_d = W_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Each source only touches a slot in one specific state, so at most one fires per slot.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            if (free_cur && (cur_slot_q == SLOT_W'(i))) begin
                slot_d[i] = SLOT_FREE;
            end
            if (commit_cur && (cur_slot_q == SLOT_W'(i))) begin
                slot_d[i] = SLOT_FULL;
            end
            if (alloc && (free_idx == SLOT_W'(i))) begin
                slot_d[i] = SLOT_FILL;
            end
            if (fifo_pop && (head_slot == SLOT_W'(i)) && (slot_q[i] == SLOT_FULL)) begin
                slot_d[i] = SLOT_READ;
            end
            if (bus.rd_done && (bus.rd_done_slot == SLOT_W'(i)) && (slot_q[i] == SLOT_READ)) begin
                slot_d[i] = SLOT_FREE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate_q   <= W_IDLE;
            cur_slot_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= SLOT_FREE;
            end
        end else begin
            wstate_q   <= wstate_d;
            cur_slot_q <= cur_slot_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // The committing slot is not yet queued, so the queue always has room for it.
    assign fifo_push = commit_cur && !fifo_full;
    assign fifo_pop  = !fifo_empty && bus.rd_ready;

    mac_rx_slot_fifo #(
        .DEPTH  (NUM_SLOTS),
        .DATA_W (SLOT_W + LEN_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({cur_slot_q, bus.wr_len}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_slot, head_len} = fifo_head;

    assign bus.rd_valid   = !fifo_empty;
    assign bus.rd_slot    = head_slot;
    assign bus.rd_len     = head_len;
    assign bus.wr_slot_en = in_frame;
    assign bus.wr_slot    = cur_slot_q;

`ifdef RX_STATS_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [3:0]       inc_vec;

    assign inc_vec = {inc_err, inc_filt, inc_nobuf, inc_ok};

    // Saturating counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (stats_clr) begin
                    cnt_q[i] <= '0;
                end else if (inc_vec[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign cnt_ok    = cnt_q[0];
    assign cnt_nobuf = cnt_q[1];
    assign cnt_filt  = cnt_q[2];
    assign cnt_err   = cnt_q[3];
`else
    logic unused_stats;
    assign unused_stats = ^{stats_clr, inc_ok, inc_nobuf, inc_filt, inc_err};

    assign cnt_ok    = '0;
    assign cnt_nobuf = '0;
    assign cnt_filt  = '0;
    assign cnt_err   = '0;
`endif

endmodule

// File: tb/tb_mac_rx_buf_ctrl.sv
// Scoreboard bench for mac_rx_buf_ctrl: directed frames, popped {slot, len} checked in order.
module tb_mac_rx_buf_ctrl;
    localparam int SLOT_W = 1;
    localparam int LEN_W  = 11;
    localparam int CNT_W  = 16;
`ifdef RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MCAST_MAC = 48'h01_00_5E_00_00_01;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

    logic             clk;
    logic             rst;
    logic             config_ready;
    logic [47:0]      local_mac;
    logic             accept_mcast;
    logic             stats_clr;
    logic [CNT_W-1:0] cnt_ok;
    logic [CNT_W-1:0] cnt_nobuf;
    logic [CNT_W-1:0] cnt_filt;
    logic [CNT_W-1:0] cnt_err;

    mac_rx_buf_ctrl_if #(.SLOT_W(SLOT_W), .LEN_W(LEN_W)) bus ();

    mac_rx_buf_ctrl #(
        .NUM_SLOTS (2),
        .SLOT_W    (SLOT_W),
        .LEN_W     (LEN_W),
        .MAX_LEN   (1518),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .config_ready (config_ready),
        .local_mac    (local_mac),
        .accept_mcast (accept_mcast),
        .stats_clr    (stats_clr),
        .bus          (bus),
        .cnt_ok       (cnt_ok),
        .cnt_nobuf    (cnt_nobuf),
        .cnt_filt     (cnt_filt),
        .cnt_err      (cnt_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ok    = 0;
    int exp_nobuf = 0;
    int exp_filt  = 0;
    int exp_err   = 0;
    logic [SLOT_W+LEN_W-1:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_cnt_ok"},    64'(cnt_ok),    STATS ? 64'(exp_ok)    : 64'd0);
        checkOutput({tag, "_cnt_nobuf"}, 64'(cnt_nobuf), STATS ? 64'(exp_nobuf) : 64'd0);
        checkOutput({tag, "_cnt_filt"},  64'(cnt_filt),  STATS ? 64'(exp_filt)  : 64'd0);
        checkOutput({tag, "_cnt_err"},   64'(cnt_err),   STATS ? 64'(exp_err)   : 64'd0);
    endtask

    // Monitor: every accepted head entry must match the oldest expected entry.
    always @(negedge clk) begin
        logic [SLOT_W+LEN_W-1:0] exp_entry;
        if (rst && bus.rd_valid && bus.rd_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_pop: got slot %0d len %0d, expected no entry",
                         bus.rd_slot, bus.rd_len);
            end else begin
                exp_entry = sb.pop_front();
                checkOutput("pop_slot", 64'(bus.rd_slot), 64'(exp_entry[LEN_W +: SLOT_W]));
                checkOutput("pop_len",  64'(bus.rd_len),  64'(exp_entry[LEN_W-1:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sofPulse();
        bus.wr_sof = 1'b1;
        tick();
        bus.wr_sof = 1'b0;
    endtask

    task automatic hdrPulse(input logic [47:0] dest);
        bus.wr_hdr_valid = 1'b1;
        bus.wr_dest_mac  = dest;
        tick();
        bus.wr_hdr_valid = 1'b0;
    endtask

    task automatic eofPulse(input logic [LEN_W-1:0] len, input logic fcs);
        bus.wr_eof    = 1'b1;
        bus.wr_len    = len;
        bus.wr_fcs_ok = fcs;
        tick();
        bus.wr_eof = 1'b0;
    endtask

    task automatic releaseSlot(input logic [SLOT_W-1:0] s);
        repeat (2) tick();
        bus.rd_done      = 1'b1;
        bus.rd_done_slot = s;
        tick();
        bus.rd_done = 1'b0;
    endtask

    // One complete frame with hand-computed expectations for allocation, filtering and commit.
    task automatic applyStimulus(input logic [47:0] dest, input logic [LEN_W-1:0] len, input logic fcs,
                                 input bit alloc, input logic [SLOT_W-1:0] slot,
                                 input bit accept, input bit commit);
        sofPulse();
        checkOutput("sof_slot_en", 64'(bus.wr_slot_en), 64'(alloc));
        if (alloc) checkOutput("sof_slot", 64'(bus.wr_slot), 64'(slot));
        hdrPulse(dest);
        checkOutput("hdr_slot_en", 64'(bus.wr_slot_en), 64'(alloc && accept));
        repeat (2) tick();
        if (commit) sb.push_back({slot, len});
        eofPulse(len, fcs);
        checkOutput("eof_slot_en", 64'(bus.wr_slot_en), 64'd0);
        if (commit) checkOutput("commit_rd_valid", 64'(bus.rd_valid), 64'd1);
    endtask

    initial begin
        rst              = 1'b1;
        config_ready     = 1'b1;
        local_mac        = LOCAL_MAC;
        accept_mcast     = 1'b0;
        stats_clr        = 1'b0;
        bus.wr_sof       = 1'b0;
        bus.wr_hdr_valid = 1'b0;
        bus.wr_dest_mac  = '0;
        bus.wr_eof       = 1'b0;
        bus.wr_len       = '0;
        bus.wr_fcs_ok    = 1'b0;
        bus.rd_ready     = 1'b1;
        bus.rd_done      = 1'b0;
        bus.rd_done_slot = '0;
        #1 rst = 1'b0;
        #2;
        checkOutput("rst_rd_valid",   64'(bus.rd_valid),   64'd0);
        checkOutput("rst_wr_slot_en", 64'(bus.wr_slot_en), 64'd0);
        checkOutput("rst_wr_slot",    64'(bus.wr_slot),    64'd0);
        checkOutput("rst_rd_len",     64'(bus.rd_len),     64'd0);
        checkCounters("rst");
        repeat (2) tick();
        rst = 1'b1;
        tick();

        $display("[TB] test 1: single good frame");
        applyStimulus(LOCAL_MAC, 11'd64, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_ok = 1;
        checkCounters("t1");
        releaseSlot(1'b0);

        $display("[TB] test 2: reader stalled, buffers exhausted");
        bus.rd_ready = 1'b0;
        applyStimulus(LOCAL_MAC, 11'd100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(LOCAL_MAC, 11'd200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(LOCAL_MAC, 11'd300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_ok    += 2;
        exp_nobuf += 1;
        checkOutput("stall_head_slot", 64'(bus.rd_slot), 64'd0);
        checkOutput("stall_head_len",  64'(bus.rd_len),  64'd100);
        checkCounters("t2");
        bus.rd_ready = 1'b1;
        releaseSlot(1'b0);
        releaseSlot(1'b1);

        $display("[TB] test 3: multicast and broadcast filtering");
        applyStimulus(MCAST_MAC, 11'd64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_filt += 1;
        checkOutput("filt_rd_valid", 64'(bus.rd_valid), 64'd0);
        accept_mcast = 1'b1;
        applyStimulus(MCAST_MAC, 11'd72, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        releaseSlot(1'b0);
        accept_mcast = 1'b0;
        applyStimulus(BCAST, 11'd14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        releaseSlot(1'b0);
        exp_ok += 2;
        checkCounters("t3");

        $display("[TB] test 4: bad frames");
        applyStimulus(LOCAL_MAC, 11'd100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("badfcs_rd_valid", 64'(bus.rd_valid), 64'd0);
        applyStimulus(LOCAL_MAC, 11'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("runt_rd_valid", 64'(bus.rd_valid), 64'd0);
        applyStimulus(LOCAL_MAC, 11'd1519, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("giant_rd_valid", 64'(bus.rd_valid), 64'd0);
        sofPulse();
        hdrPulse(LOCAL_MAC);
        tick();
        sofPulse();
        checkOutput("abort_realloc_slot", 64'(bus.wr_slot),    64'd1);
        checkOutput("abort_slot_en",      64'(bus.wr_slot_en), 64'd1);
        checkOutput("abort_rd_valid",     64'(bus.rd_valid),   64'd0);
        exp_err += 4;
        hdrPulse(LOCAL_MAC);
        repeat (2) tick();
        sb.push_back({1'b1, 11'd80});
        eofPulse(11'd80, 1'b1);
        exp_ok += 1;
        checkCounters("t4");
        releaseSlot(1'b1);

        $display("[TB] test 5: same-cycle release/commit, config_ready drop");
        applyStimulus(LOCAL_MAC, 11'd300, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        sofPulse();
        checkOutput("t5_second_slot", 64'(bus.wr_slot), 64'd1);
        hdrPulse(LOCAL_MAC);
        tick();
        bus.rd_done      = 1'b1;
        bus.rd_done_slot = 1'b0;
        sb.push_back({1'b1, 11'd400});
        eofPulse(11'd400, 1'b1);
        bus.rd_done = 1'b0;
        checkOutput("t5_commit_rd_valid", 64'(bus.rd_valid), 64'd1);
        sofPulse();
        checkOutput("t5_realloc_slot0", 64'(bus.wr_slot), 64'd0);
        hdrPulse(LOCAL_MAC);
        tick();
        config_ready = 1'b0;
        tick();
        config_ready = 1'b1;
        checkOutput("cfg_drop_slot_en", 64'(bus.wr_slot_en), 64'd0);
        applyStimulus(LOCAL_MAC, 11'd500, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        releaseSlot(1'b0);
        releaseSlot(1'b1);
        exp_ok += 3;
        checkCounters("t5");
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        exp_ok = 0; exp_nobuf = 0; exp_filt = 0; exp_err = 0;
        checkCounters("clr");

        $display("[TB] test 6: asynchronous reset mid-frame");
        bus.rd_ready = 1'b0;
        applyStimulus(LOCAL_MAC, 11'd600, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        sofPulse();
        hdrPulse(LOCAL_MAC);
        #2 rst = 1'b0;
        sb.delete();
        #1;
        exp_ok = 0;
        checkOutput("arst_rd_valid",   64'(bus.rd_valid),   64'd0);
        checkOutput("arst_rd_slot",    64'(bus.rd_slot),    64'd0);
        checkOutput("arst_rd_len",     64'(bus.rd_len),     64'd0);
        checkOutput("arst_wr_slot_en", 64'(bus.wr_slot_en), 64'd0);
        checkOutput("arst_wr_slot",    64'(bus.wr_slot),    64'd0);
        checkCounters("arst");
        repeat (2) tick();
        rst          = 1'b1;
        bus.rd_ready = 1'b1;
        tick();
        applyStimulus(BCAST, 11'd1518, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_ok = 1;
        releaseSlot(1'b0);
        checkCounters("post_rst");
        repeat (3) tick();
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
